// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------------------------
// switch_debounce
//   Debounces five slide switches as a single 5-bit pattern. The raw levels are synchronized
//   through two flops, then a two-state FSM requires the synchronized pattern to hold for
//   DEBOUNCE_CYCLES further cycles before it is committed to the outputs.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive-cycle stability count (2 .. 2**20)
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   Sw[4:0]   raw asynchronous switch levels; Sw[4..0] -> Ch7..Ch3
//   Ch7..Ch3  registered debounced levels
//   Changed   one-cycle pulse in the cycle after a new pattern is committed
//   Settling  high while a candidate pattern is being qualified
// ---------------------------------------------------------------------------------------------
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Sw,
    output logic       Ch7,
    output logic       Ch6,
    output logic       Ch5,
    output logic       Ch4,
    output logic       Ch3,
    output logic       Changed,
    output logic       Settling
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    localparam logic [0:0] STABLE   = 1'b0;
    localparam logic [0:0] SETTLING = 1'b1;

    logic [4:0]    s1_q, s2_q;
    logic [4:0]    stable_q, stable_d;
    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic          changed_q, changed_d;

    // Next-state logic. Only the synchronized value s2_q is ever compared; the whole 5-bit
    // pattern is treated as one unit so bits never commit individually.
    always_comb begin
        stable_d  = stable_q;
        cand_d    = cand_q;
        count_d   = count_q;
        state_d   = state_q;
        changed_d = 1'b0;

        case (state_q)
            STABLE: begin
                if (s2_q != stable_q) begin
                    cand_d  = s2_q;
                    count_d = CNT_ONE;
                    state_d = SETTLING;
                end else begin
                    count_d = CNT_ZERO;
                end
            end
            SETTLING: begin
                if (s2_q == cand_q) begin
                    if (count_q == CNT_MAX) begin
                        stable_d  = cand_q;
                        changed_d = 1'b1;
                        count_d   = CNT_ZERO;
                        state_d   = STABLE;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end else if (s2_q == stable_q) begin
                    // Bounced back to the committed pattern: drop the candidate quietly.
                    count_d = CNT_ZERO;
                    state_d = STABLE;
                end else begin
                    // A different pattern restarts qualification from one.
                    cand_d  = s2_q;
                    count_d = CNT_ONE;
                end
            end
            default: begin
                count_d = CNT_ZERO;
                state_d = STABLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            cand_q    <= '0;
            count_q   <= '0;
            state_q   <= STABLE;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= Sw;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            cand_q    <= cand_d;
            count_q   <= count_d;
            state_q   <= state_d;
            changed_q <= changed_d;
        end
    end

    assign {Ch7, Ch6, Ch5, Ch4, Ch3} = stable_q;
    assign Changed  = changed_q;
    // A commit always leaves SETTLING on the same edge it raises Changed, so these never overlap.
    assign Settling = (state_q == SETTLING);

endmodule
